// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types for the bit-serial subtractor.
//   state_t : controller state. Encoding 2'd3 is unused; the controller treats
//             it as illegal and falls back to S_IDLE.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_subtractor_cell
//   One-bit full subtractor built from gate primitives, same cell style as the
//   ripple adder.
//   d    = a ^ b ^ bin
//   bout = (~a & b) | (~(a ^ b) & bin)
// Ports
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in from the less significant bit
//   d    out 1  difference bit
//   bout out 1  borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_x_b;
    logic a_n;
    logic a_x_b_n;
    logic gen_borrow;
    logic prop_borrow;

    xor u_x_ab   (a_x_b, a, b);
    xor u_x_d    (d, a_x_b, bin);
    not u_n_a    (a_n, a);
    not u_n_axb  (a_x_b_n, a_x_b);
    // Borrow is generated when a=0,b=1 and propagated when a==b.
    and u_a_gen  (gen_borrow, a_n, b);
    and u_a_prop (prop_borrow, a_x_b_n, bin);
    or  u_o_bout (bout, gen_borrow, prop_borrow);

endmodule : full_subtractor_cell

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial, LSB-first unsigned subtractor: diff = (a - b) mod 2^WIDTH and
//   borrow_out = (a < b). One bit is processed per clock through a single
//   full_subtractor_cell. Operands arrive on a valid/ready handshake; the
//   result leaves on a valid/ready handshake. A new operation cannot start
//   until the current result has been consumed.
// Parameters
//   WIDTH       operand/result width, 1..32
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-high reset
//   in_valid    in   1      a/b valid this cycle
//   in_ready    out  1      operands accepted this cycle (IDLE)
//   a           in   WIDTH  minuend
//   b           in   WIDTH  subtrahend
//   out_valid   out  1      diff/borrow_out valid (DONE)
//   out_ready   in   1      consumer takes the result this cycle
//   diff        out  WIDTH  (a - b) mod 2^WIDTH
//   borrow_out  out  1      1 iff a < b
//   busy        out  1      1 in CALC or DONE
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    import serial_sub_pkg::*;

    // Counter wide enough to hold WIDTH, so WIDTH=1 still gets a 1-bit vector.
    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] d_sr_q;
    logic [WIDTH-1:0] d_sr_d;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             cell_d;
    logic             cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the first
    // (LSB) result bit has reached position 0. Written as shift/or so that
    // WIDTH=1 needs no special case.
    assign d_sr_d = (d_sr_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    // NOTE: all state below is assigned with non-blocking (<=) so every flop
    // samples the pre-edge value of every other flop, as the hardware does.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control and the visible result are reset; the shift
            // registers, borrow flop and counter are always loaded at the
            // input handshake before they are used, so they need no reset.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        d_sr_q     <= '0;
                        br_q       <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                S_CALC: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    d_sr_q <= d_sr_d;
                    br_q   <= cell_bout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Capture the completed result straight from the
                        // cell so diff/borrow_out only change on this edge.
                        diff_q      <= d_sr_d;
                        borrow_q    <= cell_bout;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean idle state.
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor at WIDTH=2 and WIDTH=8, followed by a
//   random sweep at WIDTH=8 checked against a - b and a < b.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=2 instance
    logic       rst2, in_valid2, in_ready2, out_valid2, out_ready2, borrow2, busy2;
    logic [1:0] a2, b2, diff2;

    // WIDTH=8 instance
    logic       rst8, in_valid8, in_ready8, out_valid8, out_ready8, borrow8, busy8;
    logic [7:0] a8, b8, diff8;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .a          (a2),
        .b          (b2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .diff       (diff2),
        .borrow_out (borrow2),
        .busy       (busy2)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst8),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .a          (a8),
        .b          (b8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .diff       (diff8),
        .borrow_out (borrow8),
        .busy       (busy8)
    );

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=2 operation with garbage on a/b and in_valid held high during
    // CALC/DONE, optional backpressure, then release and check the held result.
    task automatic op2(input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] ed, input logic eb, input int hold);
        a2 = a; b2 = b; in_valid2 = 1'b1;
        tick();                                  // handshake edge T
        a2 = ~a; b2 = ~b;                        // garbage, in_valid still high
        check("w2_calc_in_ready", 8'(in_ready2), 8'd0);
        check("w2_calc_busy",     8'(busy2),     8'd1);
        tick();                                  // edge T+1
        check("w2_calc_no_valid", 8'(out_valid2), 8'd0);
        tick();                                  // edge T+2 -> DONE
        check("w2_done_valid",    8'(out_valid2), 8'd1);
        check("w2_done_diff",     8'(diff2),      8'(ed));
        check("w2_done_borrow",   8'(borrow2),    8'(eb));
        check("w2_done_in_ready", 8'(in_ready2),  8'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("w2_hold_valid",    8'(out_valid2), 8'd1);
            check("w2_hold_diff",     8'(diff2),      8'(ed));
            check("w2_hold_borrow",   8'(borrow2),    8'(eb));
            check("w2_hold_in_ready", 8'(in_ready2),  8'd0);
        end
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        tick();                                  // result consumed
        out_ready2 = 1'b0;
        check("w2_idle_valid",    8'(out_valid2), 8'd0);
        check("w2_idle_in_ready", 8'(in_ready2),  8'd1);
        check("w2_idle_busy",     8'(busy2),      8'd0);
        check("w2_idle_diff",     8'(diff2),      8'(ed));
        check("w2_idle_borrow",   8'(borrow2),    8'(eb));
    endtask

    // One WIDTH=8 operation; exact=1 checks the cycle-exact latency,
    // otherwise waits for out_valid within a bounded number of cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit exact);
        logic [7:0] ed;
        logic       eb;
        ed = a - b;
        eb = (a < b);
        a8 = a; b8 = b; in_valid8 = 1'b1;
        tick();                                  // handshake edge T
        in_valid8 = 1'b0;
        check("w8_calc_in_ready", 8'(in_ready8), 8'd0);
        if (exact) begin
            repeat (7) tick();                   // edge T+7, still CALC
            check("w8_lat_early", 8'(out_valid8), 8'd0);
            tick();                              // edge T+8 -> DONE
        end else begin
            for (int i = 0; i < 12 && out_valid8 !== 1'b1; i++) tick();
        end
        check("w8_valid",  8'(out_valid8), 8'd1);
        check("w8_diff",   diff8,          ed);
        check("w8_borrow", 8'(borrow8),    8'(eb));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("w8_idle_in_ready", 8'(in_ready8), 8'd1);
    endtask

    initial begin
        rst2 = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
        rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        tick();
        check("rst_in_ready",  8'(in_ready2),  8'd1);
        check("rst_out_valid", 8'(out_valid2), 8'd0);
        check("rst_diff",      8'(diff2),      8'd0);
        check("rst_borrow",    8'(borrow2),    8'd0);
        check("rst_busy",      8'(busy2),      8'd0);
        check("rst8_in_ready", 8'(in_ready8),  8'd1);
        rst2 = 1'b0;
        rst8 = 1'b0;

        // WIDTH=2 directed operations
        op2(2'd3, 2'd1, 2'd2, 1'b0, 5);          // 3-1 with 5 cycles backpressure
        op2(2'd1, 2'd2, 2'd3, 1'b1, 0);          // 1-2 wraps
        op2(2'd2, 2'd2, 2'd0, 1'b0, 0);          // equal operands
        op2(2'd0, 2'd1, 2'd3, 1'b1, 0);          // 0-1 -> all ones
        op2(2'd1, 2'd3, 2'd2, 1'b1, 0);          // 1-3 -> 2, borrow

        // Reset in the middle of CALC aborts the operation
        a2 = 2'd3; b2 = 2'd0; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("midrst_in_ready",  8'(in_ready2),  8'd1);
        check("midrst_out_valid", 8'(out_valid2), 8'd0);
        check("midrst_diff",      8'(diff2),      8'd0);
        check("midrst_borrow",    8'(borrow2),    8'd0);
        check("midrst_busy",      8'(busy2),      8'd0);
        tick();
        check("midrst_no_result", 8'(out_valid2), 8'd0);
        op2(2'd3, 2'd1, 2'd2, 1'b0, 0);

        // WIDTH=8 latency and wrap, then corners and a random sweep
        op8(8'h00, 8'h01, 1'b1);
        op8(8'hFF, 8'h00, 1'b0);
        op8(8'h00, 8'hFF, 1'b0);
        op8(8'h80, 8'h80, 1'b0);
        op8(8'h5A, 8'hA5, 1'b0);
        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom), 8'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound on run time so a stuck handshake cannot hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor
